sf_parser_mc: RTL and testbench

Bit-serial MPEG-1 Layer III scalefactor parser for the main-data stream. One instance serves every granule/channel: gr and ch are selected at run time when side info is presented. It parses long, short and mixed blocks, and applies scfsi reuse from a per-channel granule-0 history. It sits between the main-data bit reservoir (axiid/axiiv source) and the Huffman/requantiser stage, and reports part2_length so the Huffman stage knows where its data starts.

---
 rtl/sf_pkg.sv | 77 +++++++
 rtl/sf_parser_mc_history.sv | 35 +++
 rtl/sf_parser_mc.sv | 166 ++++++++++++++++
 tb/tb_sf_parser_mc.sv | 311 +++++++++++++++++++++++++++++++
 4 files changed

// File: rtl/sf_pkg.sv
// Shared tables, state/block enums and field-mapping helpers for the
// MPEG-1 Layer III scalefactor parser.
package sf_pkg;

  localparam int NUM_SFB_L        = 21;
  localparam int NUM_SFB_S        = 12;
  localparam int MIXED_L_END      = 8;
  localparam int MIXED_S_START    = 3;
  localparam int SHORT_SLEN2_SFB  = 6;
  localparam int NUM_FIELDS       = NUM_SFB_S * 3;

  localparam logic [2:0] SLEN1 [16] = '{3'd0, 3'd0, 3'd0, 3'd0, 3'd3, 3'd1, 3'd1, 3'd1,
                                        3'd2, 3'd2, 3'd2, 3'd3, 3'd3, 3'd3, 3'd4, 3'd4};
  localparam logic [2:0] SLEN2 [16] = '{3'd0, 3'd1, 3'd2, 3'd3, 3'd0, 3'd1, 3'd2, 3'd3,
                                        3'd1, 3'd2, 3'd3, 3'd1, 3'd2, 3'd3, 3'd2, 3'd3};
  localparam int LONG_BOUND [5] = '{0, 6, 11, 16, 21};

  typedef enum logic [1:0] {ST_IDLE, ST_SETUP, ST_READ, ST_DONE} state_t;
  typedef enum logic [1:0] {BLK_LONG, BLK_SHORT, BLK_MIXED} blk_t;

  typedef struct packed {
    logic       is_long;
    logic [4:0] sfb;
    logic [1:0] win;
  } field_t;

  function automatic logic [1:0] long_group(input int sfb);
    logic [1:0] g;
    if (sfb < LONG_BOUND[1])      g = 2'd0;
    else if (sfb < LONG_BOUND[2]) g = 2'd1;
    else if (sfb < LONG_BOUND[3]) g = 2'd2;
    else                          g = 2'd3;
    return g;
  endfunction

  // Flat field index f walks the block in bitstream order; this maps it to its destination.
  function automatic field_t field_map(input blk_t blk, input int f);
    field_t m;
    int     s;
    m = '0;
    if (blk == BLK_LONG || (blk == BLK_MIXED && f < MIXED_L_END)) begin
      m.is_long = 1'b1;
      m.sfb     = 5'(f);
    end else begin
      s     = (blk == BLK_MIXED) ? f - MIXED_L_END + 3 * MIXED_S_START : f;
      m.sfb = 5'(s / 3);
      m.win = 2'(s % 3);
    end
    return m;
  endfunction

  // Bits to read for field f; zero means the field is absent, skipped or reused from history.
  function automatic logic [2:0] field_slen(input blk_t blk, input int f,
                                            input logic [2:0] s1, input logic [2:0] s2,
                                            input logic gr, input logic [3:0] scfsi);
    field_t     m;
    logic [1:0] g;
    logic [2:0] len;
    int         limit;
    m     = field_map(blk, f);
    limit = (blk == BLK_LONG)  ? NUM_SFB_L :
            (blk == BLK_SHORT) ? 3 * NUM_SFB_S :
                                 MIXED_L_END + 3 * (NUM_SFB_S - MIXED_S_START);
    len = 3'd0;
    if (f < limit) begin
      if (m.is_long) begin
        g   = long_group(int'(m.sfb));
        len = (g < 2'd2) ? s1 : s2;
        if (blk == BLK_LONG && gr && scfsi[g]) len = 3'd0;
      end else begin
        len = (int'(m.sfb) < SHORT_SLEN2_SFB) ? s1 : s2;
      end
    end
    return len;
  endfunction

endpackage

// File: rtl/sf_parser_mc_history.sv
// Per-channel granule-0 long scalefactor history used for scfsi reuse in granule 1.
module sf_history
  import sf_pkg::*;
#(
  parameter int NUM_CH = 2,
  parameter int SF_W   = 4,
  parameter int CH_W   = 1
) (
  input  logic                              clk,
  input  logic                              rst,
  input  logic                              we,
  input  logic [CH_W-1:0]                   wr_ch,
  input  logic [NUM_SFB_L-1:0][SF_W-1:0]    wr_data,
  input  logic [CH_W-1:0]                   rd_ch,
  output logic [NUM_SFB_L-1:0][SF_W-1:0]    rd_data
);

  logic [NUM_SFB_L-1:0][SF_W-1:0] mem [NUM_CH];

  always_ff @(posedge clk) begin
    if (rst) begin
      for (int c = 0; c < NUM_CH; c++) mem[c] <= '0;
    end else if (we) begin
      for (int c = 0; c < NUM_CH; c++)
        if (wr_ch == CH_W'(c)) mem[c] <= wr_data;
    end
  end

  always_comb begin
    rd_data = '0;
    for (int c = 0; c < NUM_CH; c++)
      if (rd_ch == CH_W'(c)) rd_data = mem[c];
  end

endmodule

// File: rtl/sf_parser_mc.sv
// Bit-serial Layer III scalefactor parser: long/short/mixed blocks with scfsi
// reuse, reporting part2_length to the Huffman stage.
module sf_parser_mc
  import sf_pkg::*;
#(
  parameter  int NUM_CH = 2,
  parameter  int SF_W   = 4,
  localparam int CH_W   = (NUM_CH > 1) ? $clog2(NUM_CH) : 1
) (
  input  logic                            clk,
  input  logic                            rst,
  input  logic                            si_valid,
  input  logic                            gr_in,
  input  logic [CH_W-1:0]                 ch_in,
  input  logic [3:0]                      scalefac_compress_in,
  input  logic                            window_switching_flag_in,
  input  logic [1:0]                      block_type_in,
  input  logic                            mixed_block_flag_in,
  input  logic [3:0]                      scfsi_in,
  input  logic                            axiid,
  input  logic                            axiiv,
  output logic                            axiir,
  output logic [20:0][SF_W-1:0]           scalefac_l,
  output logic [11:0][2:0][SF_W-1:0]      scalefac_s,
  output logic [11:0]                     part2_length,
  output logic                            gr_out,
  output logic [CH_W-1:0]                 ch_out,
  output logic                            axiov,
  output logic                            busy
);

  state_t      state, state_next;
  logic        gr_q;
  logic [CH_W-1:0] ch_q;
  logic [3:0]  comp_q;
  blk_t        blk_q;
  logic [3:0]  scfsi_q;
  logic [5:0]  cur;
  logic [2:0]  bit_cnt;

  logic [2:0]  s1, s2, cur_slen;
  logic        first_has, next_has, last_bit, accept, hist_we;
  logic [5:0]  first_idx, next_idx;
  field_t      cur_map;
  logic [NUM_SFB_L-1:0][SF_W-1:0] hist_rd;

  sf_history #(.NUM_CH(NUM_CH), .SF_W(SF_W), .CH_W(CH_W)) u_history (
    .clk     (clk),
    .rst     (rst),
    .we      (hist_we),
    .wr_ch   (ch_q),
    .wr_data (scalefac_l),
    .rd_ch   (ch_q),
    .rd_data (hist_rd)
  );

  // Priority search lets the parser hop over any run of empty fields in zero cycles.
  always_comb begin
    s1        = SLEN1[comp_q];
    s2        = SLEN2[comp_q];
    first_has = 1'b0;
    first_idx = '0;
    next_has  = 1'b0;
    next_idx  = '0;
    for (int i = NUM_FIELDS - 1; i >= 0; i--) begin
      if (field_slen(blk_q, i, s1, s2, gr_q, scfsi_q) != 3'd0) begin
        first_has = 1'b1;
        first_idx = 6'(i);
        if (6'(i) > cur) begin
          next_has = 1'b1;
          next_idx = 6'(i);
        end
      end
    end
    cur_slen = field_slen(blk_q, int'(cur), s1, s2, gr_q, scfsi_q);
    cur_map  = field_map(blk_q, int'(cur));
    last_bit = (bit_cnt + 3'd1) == cur_slen;
    accept   = axiiv && (state == ST_READ);
    hist_we  = (state == ST_DONE) && !gr_q && (blk_q != BLK_SHORT);
  end

  always_ff @(posedge clk) begin
    if (rst) state <= ST_IDLE;
    else     state <= state_next;
  end

  always_comb begin
    state_next = state;
    axiir      = 1'b0;
    axiov      = 1'b0;
    busy       = 1'b1;
    case (state)
      ST_IDLE: begin
        busy = 1'b0;
        if (si_valid) state_next = ST_SETUP;
      end
      ST_SETUP: state_next = first_has ? ST_READ : ST_DONE;
      ST_READ: begin
        axiir = 1'b1;
        if (accept && last_bit && !next_has) state_next = ST_DONE;
      end
      ST_DONE: begin
        axiov      = 1'b1;
        state_next = ST_IDLE;
      end
      default: state_next = ST_IDLE;
    endcase
  end

  // Bits shift straight into their destination, which SETUP has already zeroed.
  always_ff @(posedge clk) begin
    if (rst) begin
      gr_q         <= 1'b0;
      ch_q         <= '0;
      comp_q       <= '0;
      blk_q        <= BLK_LONG;
      scfsi_q      <= '0;
      cur          <= '0;
      bit_cnt      <= '0;
      scalefac_l   <= '0;
      scalefac_s   <= '0;
      part2_length <= '0;
      gr_out       <= 1'b0;
      ch_out       <= '0;
    end else begin
      case (state)
        ST_IDLE: if (si_valid) begin
          gr_q    <= gr_in;
          ch_q    <= ch_in;
          comp_q  <= scalefac_compress_in;
          scfsi_q <= scfsi_in;
          if (window_switching_flag_in && block_type_in == 2'd2)
            blk_q <= mixed_block_flag_in ? BLK_MIXED : BLK_SHORT;
          else
            blk_q <= BLK_LONG;
        end
        ST_SETUP: begin
          for (int l = 0; l < NUM_SFB_L; l++)
            scalefac_l[l] <= (blk_q == BLK_LONG && gr_q && scfsi_q[long_group(l)]) ? hist_rd[l] : '0;
          scalefac_s   <= '0;
          part2_length <= '0;
          gr_out       <= gr_q;
          ch_out       <= ch_q;
          cur          <= first_idx;
          bit_cnt      <= '0;
        end
        ST_READ: if (accept) begin
          part2_length <= part2_length + 12'd1;
          if (cur_map.is_long)
            scalefac_l[cur_map.sfb] <= {scalefac_l[cur_map.sfb][SF_W-2:0], axiid};
          else
            scalefac_s[cur_map.sfb[3:0]][cur_map.win] <=
              {scalefac_s[cur_map.sfb[3:0]][cur_map.win][SF_W-2:0], axiid};
          if (last_bit) begin
            bit_cnt <= '0;
            cur     <= next_idx;
          end else begin
            bit_cnt <= bit_cnt + 3'd1;
          end
        end
        default: ;
      endcase
    end
  end

endmodule

// File: tb/tb_sf_parser_mc.sv
// Self-checking bench for sf_parser_mc: directed scenarios plus randomized parses
// checked against a field-list reference model.
module tb_sf_parser_mc;

  localparam int NUM_CH = 2;
  localparam int SF_W   = 4;
  localparam int CH_W   = 1;
  localparam int LIMIT  = 2000;

  logic clk = 1'b0;
  logic rst, si_valid, gr_in, window_switching_flag_in, mixed_block_flag_in;
  logic [CH_W-1:0] ch_in;
  logic [3:0] scalefac_compress_in, scfsi_in;
  logic [1:0] block_type_in;
  logic axiid, axiiv, axiir, axiov, busy, gr_out;
  logic [20:0][SF_W-1:0] scalefac_l;
  logic [11:0][2:0][SF_W-1:0] scalefac_s;
  logic [11:0] part2_length;
  logic [CH_W-1:0] ch_out;

  sf_parser_mc #(.NUM_CH(NUM_CH), .SF_W(SF_W)) dut (
    .clk(clk), .rst(rst), .si_valid(si_valid), .gr_in(gr_in), .ch_in(ch_in),
    .scalefac_compress_in(scalefac_compress_in),
    .window_switching_flag_in(window_switching_flag_in),
    .block_type_in(block_type_in), .mixed_block_flag_in(mixed_block_flag_in),
    .scfsi_in(scfsi_in), .axiid(axiid), .axiiv(axiiv), .axiir(axiir),
    .scalefac_l(scalefac_l), .scalefac_s(scalefac_s), .part2_length(part2_length),
    .gr_out(gr_out), .ch_out(ch_out), .axiov(axiov), .busy(busy)
  );

  always #5 clk = ~clk;

  int vectors = 0;
  int miscompares = 0;

  typedef struct {
    bit is_long;
    int sfb;
    int win;
    int len;
  } fld_t;

  int T1 [16] = '{0, 0, 0, 0, 3, 1, 1, 1, 2, 2, 2, 3, 3, 3, 4, 4};
  int T2 [16] = '{0, 1, 2, 3, 0, 1, 2, 3, 1, 2, 3, 1, 2, 3, 2, 3};

  bit stim_bits [128];
  logic [20:0][3:0] mhist [NUM_CH];
  logic [20:0][3:0] exp_l;
  logic [11:0][2:0][3:0] exp_s;
  int exp_len;

  logic [20:0][3:0] cap_l;
  logic [11:0][2:0][3:0] cap_s;
  logic [11:0] cap_len;
  logic cap_gr, busy_after;
  logic [CH_W-1:0] cap_ch;
  bit got_ov, saw_ready;
  int ov_cyc, last_acc, bits_used, first_rdy;

  task automatic fill_bits(input int mode);
    for (int i = 0; i < 128; i++)
      case (mode)
        0: stim_bits[i] = 1'b1;
        1: stim_bits[i] = 1'b0;
        2: stim_bits[i] = (i % 2 == 0);
        default: stim_bits[i] = 1'($urandom_range(0, 1));
      endcase
  endtask

  task automatic do_reset();
    @(negedge clk);
    rst = 1'b1; si_valid = 1'b0; axiiv = 1'b0;
    @(negedge clk);
    rst = 1'b0;
    for (int c = 0; c < NUM_CH; c++) mhist[c] = '0;
  endtask

  // Reference: list every field in bitstream order, then consume bits field by field.
  task automatic model(input logic g, input int c, input int comp, input logic wsf,
                       input logic [1:0] bt, input logic mx, input logic [3:0] sc);
    fld_t q[$];
    int s1, s2, pos, v, grp;
    bit is_short, is_mixed;
    s1 = T1[comp]; s2 = T2[comp];
    is_short = wsf && bt == 2'd2 && !mx;
    is_mixed = wsf && bt == 2'd2 && mx;
    exp_l = '0; exp_s = '0;
    if (is_short) begin
      for (int sfb = 0; sfb < 12; sfb++)
        for (int w = 0; w < 3; w++) q.push_back('{1'b0, sfb, w, (sfb < 6) ? s1 : s2});
    end else if (is_mixed) begin
      for (int sfb = 0; sfb < 8; sfb++) q.push_back('{1'b1, sfb, 0, s1});
      for (int sfb = 3; sfb < 12; sfb++)
        for (int w = 0; w < 3; w++) q.push_back('{1'b0, sfb, w, (sfb < 6) ? s1 : s2});
    end else begin
      for (int sfb = 0; sfb < 21; sfb++) begin
        grp = (sfb < 6) ? 0 : (sfb < 11) ? 1 : (sfb < 16) ? 2 : 3;
        if (g && sc[grp]) exp_l[sfb] = mhist[c][sfb];
        else q.push_back('{1'b1, sfb, 0, (grp < 2) ? s1 : s2});
      end
    end
    pos = 0;
    foreach (q[k]) begin
      v = 0;
      for (int b = 0; b < q[k].len; b++) begin
        v = v * 2 + int'(stim_bits[pos]);
        pos++;
      end
      if (q[k].is_long) exp_l[q[k].sfb] = 4'(v);
      else exp_s[q[k].sfb][q[k].win] = 4'(v);
    end
    exp_len = pos;
    if (!g && !is_short) mhist[c] = exp_l;
  endtask

  task automatic run_parse(input logic g, input logic [CH_W-1:0] c, input logic [3:0] comp,
                           input logic wsf, input logic [1:0] bt, input logic mx,
                           input logic [3:0] sc, input bit gap, input bit dbl);
    int cyc, idx;
    got_ov = 0; saw_ready = 0; first_rdy = -1; last_acc = -1; ov_cyc = -1;
    idx = 0; cyc = 0;
    @(negedge clk);
    gr_in = g; ch_in = c; scalefac_compress_in = comp; window_switching_flag_in = wsf;
    block_type_in = bt; mixed_block_flag_in = mx; scfsi_in = sc; si_valid = 1'b1;
    while (!got_ov && cyc < LIMIT) begin
      @(negedge clk);
      cyc++;
      si_valid = dbl && cyc == 1;
      if (axiov) begin
        got_ov = 1; ov_cyc = cyc;
        cap_l = scalefac_l; cap_s = scalefac_s; cap_len = part2_length;
        cap_gr = gr_out; cap_ch = ch_out;
        axiiv = 1'b0;
      end else begin
        if (axiir && !saw_ready) begin saw_ready = 1; first_rdy = cyc; end
        axiiv = gap ? (cyc % 4 == 2) : 1'b1;
        axiid = (idx < 128) ? stim_bits[idx] : 1'b0;
        if (axiiv && axiir) begin idx++; last_acc = cyc; end
      end
    end
    bits_used = idx; si_valid = 1'b0; axiiv = 1'b0;
    @(negedge clk);
    busy_after = busy;
  endtask

  task automatic test_reset();
    rst = 1'b1;
    repeat (2) @(negedge clk);
    vectors++; if (axiir !== 1'b0) begin miscompares++; $display("[TB] FAIL reset_axiir: got %b expected 0", axiir); end
    vectors++; if (axiov !== 1'b0) begin miscompares++; $display("[TB] FAIL reset_axiov: got %b expected 0", axiov); end
    vectors++; if (busy !== 1'b0) begin miscompares++; $display("[TB] FAIL reset_busy: got %b expected 0", busy); end
    vectors++; if (part2_length !== 12'd0) begin miscompares++; $display("[TB] FAIL reset_len: got %0d expected 0", part2_length); end
    vectors++; if (scalefac_l !== '0 || scalefac_s !== '0) begin miscompares++; $display("[TB] FAIL reset_sf: got %h / %h expected 0", scalefac_l, scalefac_s); end
    vectors++; if (gr_out !== 1'b0 || ch_out !== '0) begin miscompares++; $display("[TB] FAIL reset_echo: got %b/%b expected 0/0", gr_out, ch_out); end
    rst = 1'b0;
    for (int c = 0; c < NUM_CH; c++) mhist[c] = '0;
  endtask

  task automatic test_long_ones();
    fill_bits(0);
    model(1'b0, 0, 15, 1'b0, 2'd0, 1'b0, 4'h0);
    run_parse(1'b0, 1'b0, 4'd15, 1'b0, 2'd0, 1'b0, 4'h0, 1'b0, 1'b0);
    vectors++; if (bits_used != 74) begin miscompares++; $display("[TB] FAIL long_bits: got %0d expected 74", bits_used); end
    vectors++; if (cap_len !== 12'd74) begin miscompares++; $display("[TB] FAIL long_len: got %0d expected 74", cap_len); end
    vectors++; if (cap_l[0] !== 4'd15 || cap_l[10] !== 4'd15 || cap_l[11] !== 4'd7 || cap_l[20] !== 4'd7) begin miscompares++; $display("[TB] FAIL long_vals: got %h expected 15s then 7s", cap_l); end
    vectors++; if (cap_l !== exp_l) begin miscompares++; $display("[TB] FAIL long_l: got %h expected %h", cap_l, exp_l); end
    vectors++; if (ov_cyc != last_acc + 1) begin miscompares++; $display("[TB] FAIL long_latency: got %0d expected %0d", ov_cyc, last_acc + 1); end
    vectors++; if (first_rdy != 2) begin miscompares++; $display("[TB] FAIL long_ready: got %0d expected 2", first_rdy); end
    vectors++; if (busy_after !== 1'b0) begin miscompares++; $display("[TB] FAIL long_busy: got %b expected 0", busy_after); end
  endtask

  task automatic test_short_alt();
    fill_bits(2);
    model(1'b0, 0, 15, 1'b1, 2'd2, 1'b0, 4'hF);
    run_parse(1'b0, 1'b0, 4'd15, 1'b1, 2'd2, 1'b0, 4'hF, 1'b0, 1'b0);
    vectors++; if (cap_len !== 12'd126 || bits_used != 126) begin miscompares++; $display("[TB] FAIL short_len: got %0d/%0d expected 126", cap_len, bits_used); end
    vectors++; if (cap_s[0][0] !== 4'b1010 || cap_s[6][0] !== 4'b0101) begin miscompares++; $display("[TB] FAIL short_vals: got %b %b expected 1010 0101", cap_s[0][0], cap_s[6][0]); end
    vectors++; if (cap_s !== exp_s) begin miscompares++; $display("[TB] FAIL short_s: got %h expected %h", cap_s, exp_s); end
    vectors++; if (cap_l !== '0) begin miscompares++; $display("[TB] FAIL short_l: got %h expected 0", cap_l); end
  endtask

  task automatic test_mixed();
    logic [3:0] s3;
    fill_bits(3);
    s3 = {stim_bits[32], stim_bits[33], stim_bits[34], stim_bits[35]};
    model(1'b0, 1, 15, 1'b1, 2'd2, 1'b1, 4'h0);
    run_parse(1'b0, 1'b1, 4'd15, 1'b1, 2'd2, 1'b1, 4'h0, 1'b0, 1'b0);
    vectors++; if (cap_len !== 12'd122) begin miscompares++; $display("[TB] FAIL mixed_len: got %0d expected 122", cap_len); end
    vectors++; if (cap_s[3][0] !== s3) begin miscompares++; $display("[TB] FAIL mixed_s30: got %h expected %h", cap_s[3][0], s3); end
    vectors++; if (cap_s[0] !== '0 || cap_s[1] !== '0 || cap_s[2] !== '0) begin miscompares++; $display("[TB] FAIL mixed_s012: got %h expected 0", cap_s[2:0]); end
    vectors++; if (cap_l !== exp_l || cap_s !== exp_s) begin miscompares++; $display("[TB] FAIL mixed_all: got %h %h expected %h %h", cap_l, cap_s, exp_l, exp_s); end
  endtask

  task automatic test_scfsi();
    do_reset();
    fill_bits(0);
    model(1'b0, 1, 10, 1'b0, 2'd0, 1'b0, 4'h0);
    run_parse(1'b0, 1'b1, 4'd10, 1'b0, 2'd0, 1'b0, 4'h0, 1'b0, 1'b0);
    vectors++; if (cap_len !== 12'd52 || cap_ch !== 1'b1) begin miscompares++; $display("[TB] FAIL scfsi_g0: got len %0d ch %b expected 52 1", cap_len, cap_ch); end
    fill_bits(1);
    model(1'b1, 1, 10, 1'b0, 2'd0, 1'b0, 4'b0101);
    run_parse(1'b1, 1'b1, 4'd10, 1'b0, 2'd0, 1'b0, 4'b0101, 1'b0, 1'b0);
    vectors++; if (bits_used != 25 || cap_len !== 12'd25) begin miscompares++; $display("[TB] FAIL scfsi_bits: got %0d/%0d expected 25", bits_used, cap_len); end
    vectors++; if (cap_l[0] !== 4'd3 || cap_l[5] !== 4'd3 || cap_l[11] !== 4'd7 || cap_l[15] !== 4'd7 || cap_l[6] !== 4'd0 || cap_l[16] !== 4'd0) begin miscompares++; $display("[TB] FAIL scfsi_vals: got %h", cap_l); end
    vectors++; if (cap_l !== exp_l || cap_gr !== 1'b1) begin miscompares++; $display("[TB] FAIL scfsi_l: got %h gr %b expected %h gr 1", cap_l, cap_gr, exp_l); end
    model(1'b1, 0, 10, 1'b0, 2'd0, 1'b0, 4'hF);
    run_parse(1'b1, 1'b0, 4'd10, 1'b0, 2'd0, 1'b0, 4'hF, 1'b0, 1'b0);
    vectors++; if (cap_l !== '0 || bits_used != 0) begin miscompares++; $display("[TB] FAIL scfsi_ch0: got %h bits %0d expected 0", cap_l, bits_used); end
  endtask

  task automatic test_zero_compress();
    fill_bits(0);
    model(1'b0, 0, 0, 1'b0, 2'd0, 1'b0, 4'h0);
    run_parse(1'b0, 1'b0, 4'd0, 1'b0, 2'd0, 1'b0, 4'h0, 1'b0, 1'b1);
    vectors++; if (ov_cyc != 2) begin miscompares++; $display("[TB] FAIL zero_latency: got %0d expected 2", ov_cyc); end
    vectors++; if (saw_ready) begin miscompares++; $display("[TB] FAIL zero_ready: got %b expected 0", saw_ready); end
    vectors++; if (cap_len !== 12'd0) begin miscompares++; $display("[TB] FAIL zero_len: got %0d expected 0", cap_len); end
    vectors++; if (busy_after !== 1'b0) begin miscompares++; $display("[TB] FAIL zero_dbl_strobe: got busy %b expected 0", busy_after); end
  endtask

  task automatic test_gaps();
    logic [20:0][3:0] ref_l;
    fill_bits(3);
    model(1'b0, 0, 13, 1'b1, 2'd1, 1'b0, 4'h0);
    run_parse(1'b0, 1'b0, 4'd13, 1'b1, 2'd1, 1'b0, 4'h0, 1'b0, 1'b0);
    ref_l = cap_l;
    model(1'b0, 0, 13, 1'b1, 2'd1, 1'b0, 4'h0);
    run_parse(1'b0, 1'b0, 4'd13, 1'b1, 2'd1, 1'b0, 4'h0, 1'b1, 1'b0);
    vectors++; if (cap_l !== exp_l || ref_l !== exp_l) begin miscompares++; $display("[TB] FAIL gap_l: got %h / %h expected %h", ref_l, cap_l, exp_l); end
    vectors++; if (int'(cap_len) != exp_len) begin miscompares++; $display("[TB] FAIL gap_len: got %0d expected %0d", cap_len, exp_len); end
    vectors++; if (ov_cyc != last_acc + 1) begin miscompares++; $display("[TB] FAIL gap_latency: got %0d expected %0d", ov_cyc, last_acc + 1); end
  endtask

  task automatic test_reset_mid();
    bit ov_seen;
    do_reset();
    fill_bits(0);
    model(1'b0, 0, 15, 1'b0, 2'd0, 1'b0, 4'h0);
    run_parse(1'b0, 1'b0, 4'd15, 1'b0, 2'd0, 1'b0, 4'h0, 1'b0, 1'b0);
    fill_bits(3);
    ov_seen = 0;
    @(negedge clk);
    gr_in = 1'b0; ch_in = 1'b0; scalefac_compress_in = 4'd15; window_switching_flag_in = 1'b0;
    block_type_in = 2'd0; mixed_block_flag_in = 1'b0; scfsi_in = 4'h0; si_valid = 1'b1;
    for (int cyc = 1; cyc <= 12; cyc++) begin
      @(negedge clk);
      si_valid = 1'b0;
      if (axiov) ov_seen = 1;
      axiiv = (cyc % 4 == 2);
      axiid = stim_bits[cyc];
    end
    rst = 1'b1; axiiv = 1'b0;
    @(negedge clk);
    rst = 1'b0;
    vectors++; if (busy !== 1'b0 || part2_length !== 12'd0) begin miscompares++; $display("[TB] FAIL midrst_state: got busy %b len %0d expected 0 0", busy, part2_length); end
    for (int cyc = 0; cyc < 4; cyc++) begin
      if (axiov) ov_seen = 1;
      @(negedge clk);
    end
    vectors++; if (ov_seen) begin miscompares++; $display("[TB] FAIL midrst_axiov: got 1 expected 0"); end
    for (int c = 0; c < NUM_CH; c++) mhist[c] = '0;
    fill_bits(1);
    model(1'b1, 0, 15, 1'b0, 2'd0, 1'b0, 4'hF);
    run_parse(1'b1, 1'b0, 4'd15, 1'b0, 2'd0, 1'b0, 4'hF, 1'b0, 1'b0);
    vectors++; if (cap_l !== '0 || bits_used != 0 || !got_ov) begin miscompares++; $display("[TB] FAIL midrst_hist: got %h bits %0d ov %b expected 0 0 1", cap_l, bits_used, got_ov); end
  endtask

  task automatic test_random();
    logic g, wsf, mx, gap, dbl;
    logic [CH_W-1:0] c;
    logic [3:0] comp, sc;
    logic [1:0] bt;
    int kind;
    for (int n = 0; n < 30; n++) begin
      g = 1'($urandom_range(0, 1)); c = CH_W'($urandom_range(0, NUM_CH - 1));
      comp = 4'($urandom_range(0, 15)); sc = 4'($urandom_range(0, 15));
      gap = 1'($urandom_range(0, 1)); dbl = 1'($urandom_range(0, 1));
      kind = $urandom_range(0, 2);
      wsf = (kind != 0) ? 1'b1 : 1'($urandom_range(0, 1));
      bt = (kind != 0) ? 2'd2 : (wsf ? 2'(2 * $urandom_range(0, 1) + 1) : 2'($urandom_range(0, 3)));
      mx = (kind == 2) ? 1'b1 : (kind == 1) ? 1'b0 : 1'($urandom_range(0, 1));
      fill_bits(3);
      model(g, int'(c), int'(comp), wsf, bt, mx, sc);
      run_parse(g, c, comp, wsf, bt, mx, sc, gap, dbl);
      vectors++; if (!got_ov) begin miscompares++; $display("[TB] FAIL rnd%0d_axiov: got none expected strobe", n); end
      vectors++; if (bits_used != exp_len || int'(cap_len) != exp_len) begin miscompares++; $display("[TB] FAIL rnd%0d_len: got %0d/%0d expected %0d", n, bits_used, cap_len, exp_len); end
      vectors++; if (cap_l !== exp_l) begin miscompares++; $display("[TB] FAIL rnd%0d_l: got %h expected %h", n, cap_l, exp_l); end
      vectors++; if (cap_s !== exp_s) begin miscompares++; $display("[TB] FAIL rnd%0d_s: got %h expected %h", n, cap_s, exp_s); end
      vectors++; if (cap_gr !== g || cap_ch !== c) begin miscompares++; $display("[TB] FAIL rnd%0d_echo: got %b/%b expected %b/%b", n, cap_gr, cap_ch, g, c); end
      vectors++; if (ov_cyc != ((exp_len == 0) ? 2 : last_acc + 1)) begin miscompares++; $display("[TB] FAIL rnd%0d_latency: got %0d last bit %0d", n, ov_cyc, last_acc); end
    end
  endtask

  initial begin
    rst = 1'b1; si_valid = 1'b0; gr_in = 1'b0; ch_in = '0; scalefac_compress_in = '0;
    window_switching_flag_in = 1'b0; block_type_in = '0; mixed_block_flag_in = 1'b0;
    scfsi_in = '0; axiid = 1'b0; axiiv = 1'b0;
    test_reset();
    test_long_ones();
    test_short_alt();
    test_mixed();
    test_scfsi();
    test_zero_compress();
    test_gaps();
    test_reset_mid();
    test_random();
    $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
    $finish;
  end

endmodule
